// File: rtl/ntt_agu_ctrl_if.sv
// rtl/ntt_agu_ctrl_if.sv - Control/address bundle between NTT sequencer and datapath.
// cycle_cnt is present only when AGU_PERF_CNT_EN is defined.
interface ntt_agu_ctrl_if #(
  parameter int LOGN = 8
);
  logic            start;
  logic            mode;
  logic            rd_en;
  logic [LOGN-1:0] rd_addr_a;
  logic [LOGN-1:0] rd_addr_b;
  logic [LOGN-1:0] tf_addr;
  logic            sel;
  logic            wr_en;
  logic [LOGN-1:0] wr_addr_a;
  logic [LOGN-1:0] wr_addr_b;
  logic            busy;
  logic            done;
`ifdef AGU_PERF_CNT_EN
  logic [15:0]     cycle_cnt;
`endif

  modport master (
    output start, mode,
`ifdef AGU_PERF_CNT_EN
    input  cycle_cnt,
`endif
    input  rd_en, rd_addr_a, rd_addr_b, tf_addr, sel,
    input  wr_en, wr_addr_a, wr_addr_b, busy, done
  );

  modport slave (
    input  start, mode,
`ifdef AGU_PERF_CNT_EN
    output cycle_cnt,
`endif
    output rd_en, rd_addr_a, rd_addr_b, tf_addr, sel,
    output wr_en, wr_addr_a, wr_addr_b, busy, done
  );
endinterface

// File: rtl/ntt_agu_ctrl.sv
// rtl/ntt_agu_ctrl.sv - NTT/INTT stage sequencer with butterfly address, twiddle and write-back generation.
// Optional busy-cycle counter: define AGU_PERF_CNT_EN.
module ntt_agu_ctrl #(
  parameter int LOGN    = 8,
  parameter int BF_LAT  = 6,
  parameter int MEM_LAT = 1
) (
  input logic           clk,
  input logic           rst,
  ntt_agu_ctrl_if.slave bus
);
  localparam int D  = MEM_LAT + BF_LAT;
  localparam int SW = (LOGN > 2) ? $clog2(LOGN) : 1;
  localparam int DW = (D > 1) ? $clog2(D) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t          state, state_nxt;
  logic [SW-1:0]   stage, stage_nxt;
  logic [LOGN-2:0] bfly, bfly_nxt;
  logic [DW-1:0]   drain, drain_nxt;
  logic            mode_lat, mode_nxt;

  always_comb begin
    state_nxt = state;
    stage_nxt = stage;
    bfly_nxt  = bfly;
    drain_nxt = drain;
    mode_nxt  = mode_lat;
    case (state)
      IDLE: if (bus.start) begin
        state_nxt = RUN;
        stage_nxt = '0;
        bfly_nxt  = '0;
        mode_nxt  = bus.mode;
      end
      RUN: if (bfly == '1) begin
        state_nxt = DRAIN;
        drain_nxt = '0;
      end else begin
        bfly_nxt = bfly + 1'b1;
      end
      DRAIN: if (drain == DW'(D - 1)) begin
        if (stage == SW'(LOGN - 1)) begin
          state_nxt = DONE;
        end else begin
          state_nxt = RUN;
          stage_nxt = stage + 1'b1;
          bfly_nxt  = '0;
        end
      end else begin
        drain_nxt = drain + 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Addresses are formed from next-state counters so they register alongside rd_en.
  logic [SW-1:0]   span_sh, tf_sh;
  logic [LOGN-1:0] jx, len, grp, addr_a, addr_b, tw;

  always_comb begin
    span_sh = mode_nxt ? stage_nxt : SW'(LOGN - 1) - stage_nxt;
    tf_sh   = mode_nxt ? SW'(LOGN - 1) - stage_nxt : stage_nxt;
    jx      = {1'b0, bfly_nxt};
    len     = LOGN'(1) << span_sh;
    grp     = jx >> span_sh;
    addr_a  = ((grp << span_sh) << 1) | (jx & (len - LOGN'(1)));
    addr_b  = addr_a | len;
    tw      = (LOGN'(1) << tf_sh) + grp;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      stage         <= '0;
      bfly          <= '0;
      drain         <= '0;
      mode_lat      <= 1'b0;
      bus.rd_en     <= 1'b0;
      bus.rd_addr_a <= '0;
      bus.rd_addr_b <= '0;
      bus.tf_addr   <= '0;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
    end else begin
      state         <= state_nxt;
      stage         <= stage_nxt;
      bfly          <= bfly_nxt;
      drain         <= drain_nxt;
      mode_lat      <= mode_nxt;
      bus.rd_en     <= (state_nxt == RUN);
      bus.rd_addr_a <= (state_nxt == RUN) ? addr_a : '0;
      bus.rd_addr_b <= (state_nxt == RUN) ? addr_b : '0;
      bus.tf_addr   <= (state_nxt == RUN) ? tw : '0;
      bus.busy      <= (state_nxt != IDLE);
      bus.done      <= (state_nxt == DONE);
    end
  end

  assign bus.sel = mode_lat;

  logic            pipe_en [D];
  logic [LOGN-1:0] pipe_a  [D];
  logic [LOGN-1:0] pipe_b  [D];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < D; i++) begin
        pipe_en[i] <= 1'b0;
        pipe_a[i]  <= '0;
        pipe_b[i]  <= '0;
      end
    end else begin
      pipe_en[0] <= bus.rd_en;
      pipe_a[0]  <= bus.rd_addr_a;
      pipe_b[0]  <= bus.rd_addr_b;
      for (int i = 1; i < D; i++) begin
        pipe_en[i] <= pipe_en[i-1];
        pipe_a[i]  <= pipe_a[i-1];
        pipe_b[i]  <= pipe_b[i-1];
      end
    end
  end

  assign bus.wr_en     = pipe_en[D-1];
  assign bus.wr_addr_a = pipe_a[D-1];
  assign bus.wr_addr_b = pipe_b[D-1];

`ifdef AGU_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.cycle_cnt <= '0;
    end else if (state == IDLE && bus.start) begin
      bus.cycle_cnt <= '0;
    end else if (bus.busy && bus.cycle_cnt != 16'hFFFF) begin
      bus.cycle_cnt <= bus.cycle_cnt + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_ntt_agu_ctrl.sv
// tb/tb_ntt_agu_ctrl.sv - Self-checking bench for ntt_agu_ctrl at LOGN=3 and default LOGN=8.
module tb_ntt_agu_ctrl;
  localparam int DD = 7;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ntt_agu_ctrl_if #(.LOGN(3)) bus3 ();
  ntt_agu_ctrl_if #(.LOGN(8)) bus8 ();

  ntt_agu_ctrl #(.LOGN(3), .BF_LAT(6), .MEM_LAT(1)) u3 (.clk(clk), .rst(rst), .bus(bus3.slave));
  ntt_agu_ctrl #(.LOGN(8), .BF_LAT(6), .MEM_LAT(1)) u8 (.clk(clk), .rst(rst), .bus(bus8.slave));

  int  tests = 0;
  int  fails = 0;
  int  cyc = 0;
  bit  model_ok = 1'b0;
  bit  act3 = 1'b0, act8 = 1'b0;
  int  c0_3 = 0, c0_8 = 0;
  bit  sel3 = 1'b0, sel8 = 1'b0;
  int  done_t3 = -1;
  int  wr_cnt8 = 0;
  int  last_rd [256];
  int  cap_a[$], cap_b[$], cap_tf[$];

  int lit_a  [2][12] = '{'{0,1,2,3, 0,1,4,5, 0,2,4,6}, '{0,2,4,6, 0,1,4,5, 0,1,2,3}};
  int lit_b  [2][12] = '{'{4,5,6,7, 2,3,6,7, 1,3,5,7}, '{1,3,5,7, 2,3,6,7, 4,5,6,7}};
  int lit_tf [2][12] = '{'{1,1,1,1, 2,2,3,3, 4,5,6,7}, '{4,5,6,7, 2,2,3,3, 1,1,1,1}};

  function automatic int tdone(input int logn);
    return logn * ((1 << logn) / 2 + DD) + 1;
  endfunction

  // What a read cycle t (t=0: cycle start is accepted) must carry, from stage/butterfly arithmetic.
  function automatic void exp_rd(input int logn, input int t, input bit md,
                                 output bit en, output int a, output int b, output int tf);
    int n, per, p, r, len, g;
    n = 1 << logn; per = n / 2 + DD;
    en = 1'b0; a = 0; b = 0; tf = 0;
    if (t >= 1) begin
      p = (t - 1) / per;
      r = (t - 1) % per;
      if (p < logn && r < n / 2) begin
        en  = 1'b1;
        len = md ? (1 << p) : (n >> (p + 1));
        g   = r / len;
        a   = 2 * len * g + r % len;
        b   = a + len;
        tf  = md ? (n >> (p + 1)) + g : (1 << p) + g;
      end
    end
  endfunction

  task automatic check(input int logn, input string nm, input bit act, input int c0, input bit selx,
                       input bit rd_en, input int ra, input int rb, input int tfa,
                       input bit wr_en, input int wa, input int wb,
                       input bit sl, input bit busy, input bit done);
    int t, ea, eb, etf, fa, fb, ftf;
    bit er, ew, ok;
    t = act ? cyc - c0 : -100;
    exp_rd(logn, t, selx, er, ea, eb, etf);
    exp_rd(logn, t - DD, selx, ew, fa, fb, ftf);
    ok = (rd_en == er) && (wr_en == ew) && (sl == selx) &&
         (busy == (t >= 1 && t <= tdone(logn))) && (done == (t == tdone(logn))) &&
         (!er || (ra == ea && rb == eb && tfa == etf)) && (!ew || (wa == fa && wb == fb));
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL cycle_%s t=%0d got rd=%0d a=%0d b=%0d tf=%0d wr=%0d wa=%0d wb=%0d sel=%0d busy=%0d done=%0d want rd=%0d a=%0d b=%0d tf=%0d wr=%0d wa=%0d wb=%0d sel=%0d",
               nm, t, rd_en, ra, rb, tfa, wr_en, wa, wb, sl, busy, done, er, ea, eb, etf, ew, fa, fb, selx);
    end
  endtask

  task automatic hz(input int x);
    if (last_rd[x] >= 0) begin
      tests++;
      if (cyc - last_rd[x] <= DD) begin
        fails++;
        $display("FAIL hazard addr=%0d read gap %0d required > %0d", x, cyc - last_rd[x], DD);
      end
    end
    last_rd[x] = cyc;
  endtask

  always @(posedge clk) begin
    if (rst) begin
      model_ok <= 1'b1;
      act3 <= 1'b0; act8 <= 1'b0; sel3 <= 1'b0; sel8 <= 1'b0;
    end else begin
      if (bus3.start && (!act3 || cyc - c0_3 > tdone(3))) begin
        act3 <= 1'b1; c0_3 <= cyc; sel3 <= bus3.mode;
      end
      if (bus8.start && (!act8 || cyc - c0_8 > tdone(8))) begin
        act8 <= 1'b1; c0_8 <= cyc; sel8 <= bus8.mode;
      end
    end
    cyc <= cyc + 1;
  end

  always @(negedge clk) begin
    if (model_ok) begin
      check(3, "u3", act3, c0_3, sel3, bus3.rd_en, int'(bus3.rd_addr_a), int'(bus3.rd_addr_b), int'(bus3.tf_addr),
            bus3.wr_en, int'(bus3.wr_addr_a), int'(bus3.wr_addr_b), bus3.sel, bus3.busy, bus3.done);
      check(8, "u8", act8, c0_8, sel8, bus8.rd_en, int'(bus8.rd_addr_a), int'(bus8.rd_addr_b), int'(bus8.tf_addr),
            bus8.wr_en, int'(bus8.wr_addr_a), int'(bus8.wr_addr_b), bus8.sel, bus8.busy, bus8.done);
      if (bus3.rd_en) begin
        cap_a.push_back(int'(bus3.rd_addr_a));
        cap_b.push_back(int'(bus3.rd_addr_b));
        cap_tf.push_back(int'(bus3.tf_addr));
      end
      if (bus3.done && act3) done_t3 = cyc - c0_3;
      if (bus8.wr_en) wr_cnt8++;
      if (bus8.rd_en) begin
        hz(int'(bus8.rd_addr_a));
        hz(int'(bus8.rd_addr_b));
      end
    end
  end

  task automatic run3(input bit md);
    cap_a.delete(); cap_b.delete(); cap_tf.delete();
    done_t3 = -1;
    @(posedge clk); #2;
    bus3.mode = md; bus3.start = 1'b1;
    @(posedge clk); #2;
    bus3.start = 1'b0; bus3.mode = ~md;
    for (int i = 0; i < 100 && done_t3 < 0; i++) @(negedge clk);
    tests++;
    if (done_t3 != 34) begin
      fails++;
      $display("FAIL done_cycle_m%0d got %0d want 34", md, done_t3);
    end
    tests++;
    if (cap_a.size() != 12) begin
      fails++;
      $display("FAIL read_count_m%0d got %0d want 12", md, cap_a.size());
    end else begin
      for (int i = 0; i < 12; i++) begin
        tests++;
        if (cap_a[i] != lit_a[md][i] || cap_b[i] != lit_b[md][i] || cap_tf[i] != lit_tf[md][i]) begin
          fails++;
          $display("FAIL pair_m%0d_%0d got (%0d,%0d) tf %0d want (%0d,%0d) tf %0d", md, i,
                   cap_a[i], cap_b[i], cap_tf[i], lit_a[md][i], lit_b[md][i], lit_tf[md][i]);
        end
      end
    end
  endtask

  initial begin
    bit seen;
    int n;
    for (int i = 0; i < 256; i++) last_rd[i] = -1;
    bus3.start = 1'b0; bus3.mode = 1'b0;
    bus8.start = 1'b0; bus8.mode = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;

    run3(1'b0);
    run3(1'b1);

    // Default-size forward run, with a start/mode pulse while busy.
    wr_cnt8 = 0;
    @(posedge clk); #2;
    bus8.mode = 1'b0; bus8.start = 1'b1;
    @(posedge clk); #2;
    bus8.start = 1'b0;
    repeat (48) @(posedge clk);
    #2 bus8.mode = 1'b1; bus8.start = 1'b1;
    @(posedge clk); #2;
    bus8.start = 1'b0; bus8.mode = 1'b0;
    n = 0;
    while (!bus8.done && n < 1200) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (!bus8.done || cyc - c0_8 != 1081) begin
      fails++;
      $display("FAIL done_default got t=%0d done=%0d want t=1081", cyc - c0_8, bus8.done);
    end
    tests++;
    if (wr_cnt8 != 1024) begin
      fails++;
      $display("FAIL write_count got %0d want 1024", wr_cnt8);
    end

    // start in the done cycle is ignored; one cycle later it is accepted.
    bus8.mode = 1'b1; bus8.start = 1'b1;
    @(posedge clk); #2;
`ifdef AGU_PERF_CNT_EN
    tests++;
    if (bus8.cycle_cnt != 16'd1081) begin
      fails++;
      $display("FAIL cycle_cnt_hold got %0d want 1081", bus8.cycle_cnt);
    end
`endif
    @(posedge clk); #2;
    bus8.start = 1'b0; bus8.mode = 1'b0;
`ifdef AGU_PERF_CNT_EN
    tests++;
    if (bus8.cycle_cnt != 16'd0) begin
      fails++;
      $display("FAIL cycle_cnt_clear got %0d want 0", bus8.cycle_cnt);
    end
`endif

    // Reset in the middle of stage 1 of the restarted run.
    repeat (148) @(posedge clk);
    #2 rst = 1'b1;
    @(posedge clk); #2;
    tests++;
    if (bus8.rd_en || bus8.wr_en || bus8.busy || bus8.done || bus8.sel || bus8.rd_addr_a != 0 || bus8.tf_addr != 0) begin
      fails++;
      $display("FAIL reset_outputs got rd=%0d wr=%0d busy=%0d done=%0d sel=%0d a=%0d tf=%0d want all 0",
               bus8.rd_en, bus8.wr_en, bus8.busy, bus8.done, bus8.sel, bus8.rd_addr_a, bus8.tf_addr);
    end
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (bus8.wr_en || bus8.done || bus8.busy) seen = 1'b1;
    end
    tests++;
    if (seen) begin
      fails++;
      $display("FAIL post_reset_activity got 1 want 0");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
